// File: rtl/mask_pkg.sv
// Shared types for the mask row packer: the packed word, a FIFO entry that
// carries the end-of-row tag with the word, and the words-per-row helper.
package mask_pkg;

    localparam int MASK_WORD_W = 32;

    typedef logic [MASK_WORD_W-1:0] mask_word_t;

    typedef struct packed {
        mask_word_t word;
        logic       last;
    } fifo_entry_t;

    // Number of packed words needed to carry one sensor row of w bits.
    function automatic int words_per_row(input int w);
        return (w + MASK_WORD_W - 1) / MASK_WORD_W;
    endfunction

endpackage

// File: rtl/mask_word_fifo.sv
// Synchronous FIFO of packed mask words with their end-of-row tags.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle. Otherwise it is ignored, and the caller decides how to report it.
module mask_word_fifo
    import mask_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  fifo_entry_t push_data,
    input  logic        pop,
    output fifo_entry_t pop_data,
    output logic        full,
    output logic        empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    fifo_entry_t   mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem_q[rd_ptr_q];

    // Next-state pointers and occupancy, wrapping explicitly at DEPTH-1.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated only with non-blocking assignments.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers alone define which entries are valid.
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/mask_row_packer.sv
// Packs the serial mask stream into 32-bit words, buffers them and delivers
// them over valid/ready with a row tag, a row index and an end-of-frame pulse.
// Optional macro MASK_PACK_MSB_FIRST_EN: fill each word from bit 31 downward,
// so padding ends up in the low bits. The default fills from bit 0 upward.
module mask_row_packer
    import mask_pkg::*;
#(
    parameter int image_sensor_w = 300,
    parameter int image_sensor_h = 300,
    parameter int fifo_depth     = 16,
    localparam int ROW_W = (image_sensor_h > 1) ? $clog2(image_sensor_h) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             rp_mask_bit,
    input  logic             rp_valid,
    input  logic             ovf_clr,
    output logic [31:0]      out_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [ROW_W-1:0] out_row_idx,
    output logic             frame_done,
    output logic             overflow
);

    localparam int COL_W = (image_sensor_w > 1) ? $clog2(image_sensor_w) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(image_sensor_w - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(image_sensor_h - 1);

    mask_word_t        word_q, word_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [COL_W-1:0]  col_cnt_q, col_cnt_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              ovf_q, ovf_d;
    logic              frame_done_q, frame_done_d;

    logic              accept;
    logic              row_end;
    logic [4:0]        bit_pos;
    mask_word_t        merged;
    logic              push;
    fifo_entry_t       push_entry;
    fifo_entry_t       head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              drop;

    // Merge the incoming bit into the partial word and decide whether it is pushed now.
    always_comb begin
        accept  = clk_en & rp_valid;
        row_end = (col_cnt_q == COL_LAST);
`ifdef MASK_PACK_MSB_FIRST_EN
        bit_pos = 5'd31 - bit_cnt_q;
`else
        bit_pos = bit_cnt_q;
`endif
        merged     = word_q | (mask_word_t'(rp_mask_bit) << bit_pos);
        push       = accept & ((bit_cnt_q == 5'd31) | row_end);
        push_entry = '{word: merged, last: row_end};

        word_d    = word_q;
        bit_cnt_d = bit_cnt_q;
        col_cnt_d = col_cnt_q;
        if (accept) begin
            col_cnt_d = row_end ? '0 : col_cnt_q + COL_W'(1);
            if (push) begin
                word_d    = '0;
                bit_cnt_d = '0;
            end else begin
                word_d    = merged;
                bit_cnt_d = bit_cnt_q + 5'd1;
            end
        end
    end

    mask_word_fifo #(
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid   = ~fifo_empty;
    assign out_word    = out_valid ? head.word : '0;
    assign out_last    = out_valid & head.last;
    assign out_row_idx = row_q;
    assign overflow    = ovf_q;
    // The pulse register always clears, so a stalled cycle cannot stretch or repeat it.
    assign frame_done  = frame_done_q & clk_en;

    assign pop  = clk_en & out_valid & out_ready;
    assign drop = push & fifo_full & ~pop;

    // Row index, end-of-frame pulse and the sticky overflow flag (a set beats a clear).
    always_comb begin
        row_d        = row_q;
        frame_done_d = 1'b0;
        if (pop && head.last) begin
            if (row_q == ROW_LAST) begin
                row_d        = '0;
                frame_done_d = 1'b1;
            end else begin
                row_d = row_q + ROW_W'(1);
            end
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clk_en && ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Packer state and flags; reset takes priority over the clock enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q       <= '0;
            bit_cnt_q    <= '0;
            col_cnt_q    <= '0;
            row_q        <= '0;
            ovf_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            word_q       <= word_d;
            bit_cnt_q    <= bit_cnt_d;
            col_cnt_q    <= col_cnt_d;
            row_q        <= row_d;
            ovf_q        <= ovf_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_mask_row_packer.sv
// Scoreboard bench for mask_row_packer. It drives a full-size instance and a
// small 8x2 instance. Expected words are computed from the row bits when the
// stimulus is issued. Monitors compare them as the DUTs deliver words.
module tb_mask_row_packer;

    localparam int W   = 300;
    localparam int H   = 300;
    localparam int NW  = (W + 31) / 32;
    localparam int SW  = 8;
    localparam int SH  = 2;

    typedef struct {
        logic [31:0] word;
        logic        last;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic        ovf_clr;

    logic        rp_mask_bit, rp_valid, out_ready;
    logic [31:0] out_word;
    logic        out_valid, out_last, frame_done, overflow;
    logic [8:0]  out_row_idx;

    logic        s_rp_mask_bit, s_rp_valid, s_out_ready;
    logic [31:0] s_out_word;
    logic        s_out_valid, s_out_last, s_frame_done, s_overflow;
    logic [0:0]  s_out_row_idx;

    int          errors = 0;
    int          checks = 0;
    exp_t        exp_q[$];
    exp_t        s_exp_q[$];
    exp_t        mon_e;
    exp_t        s_mon_e;
    int          exp_row = 0;
    int          s_row = 0;
    bit          s_fd_exp = 0;
    int          s_fd_seen = 0;
    bit          hold_pending = 0;
    logic [31:0] hold_word;
    logic        hold_last;
    logic [8:0]  hold_row;
    bit          row_bits [0:W-1];

    mask_row_packer u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_en      (clk_en),
        .rp_mask_bit (rp_mask_bit),
        .rp_valid    (rp_valid),
        .ovf_clr     (ovf_clr),
        .out_word    (out_word),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .out_row_idx (out_row_idx),
        .frame_done  (frame_done),
        .overflow    (overflow)
    );

    mask_row_packer #(
        .image_sensor_w (SW),
        .image_sensor_h (SH),
        .fifo_depth     (4)
    ) u_small (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_en      (clk_en),
        .rp_mask_bit (s_rp_mask_bit),
        .rp_valid    (s_rp_valid),
        .ovf_clr     (ovf_clr),
        .out_word    (s_out_word),
        .out_valid   (s_out_valid),
        .out_ready   (s_out_ready),
        .out_last    (s_out_last),
        .out_row_idx (s_out_row_idx),
        .frame_done  (s_frame_done),
        .overflow    (s_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Word k of a w-bit row: the bits 32k .. 32k+31 of the row, with zero padding past the row end.
    function automatic logic [31:0] pack_word(input int k, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if ((32 * k + i) < w && row_bits[32 * k + i]) begin
`ifdef MASK_PACK_MSB_FIRST_EN
                r[31 - i] = 1'b1;
`else
                r[i] = 1'b1;
`endif
            end
        end
        return r;
    endfunction

    task automatic fill_bits(input int mode);
        for (int i = 0; i < W; i++) begin
            case (mode)
                1:       row_bits[i] = 1'b1;
                2:       row_bits[i] = (i % 2 == 0);
                default: row_bits[i] = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    // Expect the first n_push words of the current row; later words are dropped by the DUT.
    task automatic queue_row(input int n_push);
        for (int k = 0; k < NW; k++) begin
            if (k < n_push) exp_q.push_back('{word: pack_word(k, W), last: (k == NW - 1)});
        end
    endtask

    task automatic send_bit(input bit b);
        rp_valid    = 1'b1;
        rp_mask_bit = b;
        @(posedge clk); #1;
        rp_valid    = 1'b0;
    endtask

    task automatic send_row(input bit gaps, input bit rand_ready);
        for (int i = 0; i < W; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            send_bit(row_bits[i]);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || s_exp_q.size() > 0) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_pending", exp_q.size() + s_exp_q.size(), 0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("empty_after_drain", {31'd0, out_valid}, 0);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        rp_valid      = 1'b1;
        rp_mask_bit   = 1'b1;
        s_rp_valid    = 1'b1;
        s_rp_mask_bit = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_row    = 0;
        s_row      = 0;
        s_fd_exp   = 0;
        rp_valid   = 1'b0;
        s_rp_valid = 1'b0;
        rst_n      = 1'b1;
    endtask

    // Monitor for the full-size instance: in-order comparison plus stall stability.
    always @(negedge clk) begin
        if (hold_pending && rst_n) begin
            check("hold_valid", {31'd0, out_valid}, 1);
            check("hold_word", out_word, hold_word);
            check("hold_last", {31'd0, out_last}, {31'd0, hold_last});
            check("hold_row", {23'd0, out_row_idx}, {23'd0, hold_row});
        end
        if (rst_n && clk_en && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got 0x%08h expected no word", out_word);
            end else begin
                mon_e = exp_q.pop_front();
                check("word", out_word, mon_e.word);
                check("last", {31'd0, out_last}, {31'd0, mon_e.last});
                check("row_idx", {23'd0, out_row_idx}, exp_row);
                if (mon_e.last) exp_row = (exp_row == H - 1) ? 0 : exp_row + 1;
            end
        end
        hold_pending = rst_n && out_valid && !(clk_en && out_ready);
        hold_word    = out_word;
        hold_last    = out_last;
        hold_row     = out_row_idx;
    end

    // Monitor for the 8x2 instance, including the end-of-frame pulse.
    always @(negedge clk) begin
        check("s_frame_done", {31'd0, s_frame_done}, {31'd0, s_fd_exp});
        if (s_frame_done) s_fd_seen++;
        s_fd_exp = 1'b0;
        if (rst_n && clk_en && s_out_valid && s_out_ready) begin
            if (s_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL s_unexpected_word: got 0x%08h expected no word", s_out_word);
            end else begin
                s_mon_e = s_exp_q.pop_front();
                check("s_word", s_out_word, s_mon_e.word);
                check("s_last", {31'd0, s_out_last}, {31'd0, s_mon_e.last});
                check("s_row_idx", {31'd0, s_out_row_idx}, s_row);
                if (s_mon_e.last) begin
                    if (s_row == SH - 1) begin
                        s_row    = 0;
                        s_fd_exp = 1'b1;
                    end else begin
                        s_row = s_row + 1;
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        clk_en        = 1'b1;
        ovf_clr       = 1'b0;
        rp_mask_bit   = 1'b0;
        rp_valid      = 1'b0;
        out_ready     = 1'b0;
        s_rp_mask_bit = 1'b0;
        s_rp_valid    = 1'b0;
        s_out_ready   = 1'b1;
        #1;

        // Reset with rp_valid held high.
        do_reset();
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_word", out_word, 0);
        check("rst_out_last", {31'd0, out_last}, 0);
        check("rst_row_idx", {23'd0, out_row_idx}, 0);
        check("rst_frame_done", {31'd0, frame_done}, 0);
        check("rst_overflow", {31'd0, overflow}, 0);
        check("rst_s_out_valid", {31'd0, s_out_valid}, 0);

        // A row of ones; the first word appears one cycle after the 32nd bit.
        fill_bits(1);
        queue_row(NW);
        out_ready = 1'b1;
        for (int i = 0; i < W; i++) begin
            send_bit(row_bits[i]);
            if (i == 30) check("valid_before_32nd", {31'd0, out_valid}, 0);
            if (i == 31) check("valid_after_32nd", {31'd0, out_valid}, 1);
        end
        wait_drain();

        // Alternating pattern with random input gaps and random back-pressure.
        fill_bits(2);
        queue_row(NW);
        send_row(1'b1, 1'b1);
        out_ready = 1'b1;
        wait_drain();

        // Overflow: two rows with no consumer; only 16 words fit.
        out_ready = 1'b0;
        fill_bits(0);
        queue_row(NW);
        send_row(1'b0, 1'b0);
        fill_bits(0);
        queue_row(6);
        for (int i = 0; i < W; i++) begin
            send_bit(row_bits[i]);
            if (i == 222) check("ovf_before_17th", {31'd0, overflow}, 0);
            if (i == 223) check("ovf_after_17th", {31'd0, overflow}, 1);
        end
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        check("ovf_cleared", {31'd0, overflow}, 0);
        fill_bits(0);
        for (int i = 0; i < 31; i++) send_bit(row_bits[i]);
        ovf_clr = 1'b1;
        send_bit(row_bits[31]);
        ovf_clr = 1'b0;
        check("ovf_set_beats_clear", {31'd0, overflow}, 1);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        check("ovf_cleared_again", {31'd0, overflow}, 0);
        out_ready = 1'b1;
        wait_drain();
        do_reset();

        // Small instance: two 8-bit rows make one frame.
        for (int r = 0; r < SH; r++) begin
            for (int i = 0; i < SW; i++) row_bits[i] = 1'($urandom_range(0, 1));
            s_exp_q.push_back('{word: pack_word(0, SW), last: 1'b1});
            for (int i = 0; i < SW; i++) begin
                s_rp_valid    = 1'b1;
                s_rp_mask_bit = row_bits[i];
                @(posedge clk); #1;
                s_rp_valid    = 1'b0;
            end
        end
        wait_drain();
        check("s_frame_done_pulses", s_fd_seen, 1);
        check("s_row_idx_wrapped", {31'd0, s_out_row_idx}, 0);

        // Clock-enable freeze in the middle of a row, then a reset mid-row.
        out_ready = 1'b0;
        fill_bits(0);
        exp_q.push_back('{word: pack_word(0, W), last: 1'b0});
        exp_q.push_back('{word: pack_word(1, W), last: 1'b0});
        for (int i = 0; i < 42; i++) send_bit(row_bits[i]);
        clk_en    = 1'b0;
        out_ready = 1'b1;
        repeat (5) begin
            rp_valid    = 1'b1;
            rp_mask_bit = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("freeze_valid", {31'd0, out_valid}, 1);
            check("freeze_word", out_word, pack_word(0, W));
            check("freeze_frame_done", {31'd0, frame_done}, 0);
        end
        rp_valid = 1'b0;
        clk_en   = 1'b1;
        for (int i = 42; i < 84; i++) send_bit(row_bits[i]);
        do_reset();
        check("reset_mid_row_empty", {31'd0, out_valid}, 0);
        fill_bits(0);
        queue_row(NW);
        send_row(1'b0, 1'b0);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
